// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: one request at a time, word-aligned memory port with byte lanes,
// aligned/extended load return. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module ysyx_23060201_lsu #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_LAT        = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_wen,
    input  logic [2:0]                req_funct3,
    input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic                      resp_err,
    output logic                      mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
    output logic [7:0]                mem_rmask,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      mem_wen,
    output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]                mem_wmask,
    output logic [DATA_WIDTH-1:0]     mem_wdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Access size encoding: 00 byte, 01 halfword, 10 word
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_align(input logic [1:0] size,
                                                         input logic uns,
                                                         input logic [DATA_WIDTH-1:0] rdata,
                                                         input logic [1:0] off);
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] res;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'b00: begin
                if (uns) res = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
                else     res = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                if (uns) res = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
                else     res = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
            end
            default: res = sh;
        endcase
        return res;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction
`else
    function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] o;
        case (size)
            2'b00:   o = off;
            2'b01:   o = {off[1], 1'b0};
            default: o = 2'b00;
        endcase
        return o;
    endfunction
`endif

    state_t                      state_r;
    logic [CNT_W-1:0]            cnt_r;
    logic                        wen_r;
    logic [1:0]                  size_r;
    logic                        uns_r;
    logic [1:0]                  off_r;
    logic                        req_ready_r;
    logic                        resp_valid_r;
    logic [DATA_WIDTH-1:0]       resp_rdata_r;
    logic                        resp_err_r;
    logic                        mem_ren_r;
    logic [MEM_ADDR_WIDTH-1:0]   mem_raddr_r;
    logic [7:0]                  mem_rmask_r;
    logic                        mem_wen_r;
    logic [MEM_ADDR_WIDTH-1:0]   mem_waddr_r;
    logic [7:0]                  mem_wmask_r;
    logic [DATA_WIDTH-1:0]       mem_wdata_r;

    logic [1:0]                  req_size_s;
    logic [1:0]                  req_off_s;
    logic                        req_err_s;
    logic [3:0]                  req_mask_s;
    logic [MEM_ADDR_WIDTH-1:0]   req_word_addr_s;

    // Decode the incoming request: size, effective lane offset, mask and error
    always_comb begin
        req_size_s      = 2'b10;
        req_off_s       = 2'b00;
        req_err_s       = 1'b0;
        req_mask_s      = 4'b0000;
        req_word_addr_s = {req_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
        if (req_funct3[1:0] == 2'b11) begin
            req_size_s = 2'b10;
        end else begin
            req_size_s = req_funct3[1:0];
        end
`ifdef LSU_MISALIGN_TRAP_EN
        req_off_s = req_addr[1:0];
        req_err_s = is_misaligned(req_size_s, req_addr[1:0]);
`else
        req_off_s = align_off(req_size_s, req_addr[1:0]);
        req_err_s = 1'b0;
`endif
        req_mask_s = lane_mask(req_size_s, req_off_s);
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            wen_r        <= 1'b0;
            size_r       <= 2'b00;
            uns_r        <= 1'b0;
            off_r        <= 2'b00;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= {DATA_WIDTH{1'b0}};
            resp_err_r   <= 1'b0;
            mem_ren_r    <= 1'b0;
            mem_raddr_r  <= {MEM_ADDR_WIDTH{1'b0}};
            mem_rmask_r  <= 8'h00;
            mem_wen_r    <= 1'b0;
            mem_waddr_r  <= {MEM_ADDR_WIDTH{1'b0}};
            mem_wmask_r  <= 8'h00;
            mem_wdata_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        wen_r       <= req_wen;
                        size_r      <= req_size_s;
                        uns_r       <= req_funct3[2];
                        off_r       <= req_off_s;
                        req_ready_r <= 1'b0;
                        if (req_err_s) begin
                            // Trapped request: answer immediately without touching memory
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= {DATA_WIDTH{1'b0}};
                        end else begin
                            state_r <= ST_ACCESS;
                            cnt_r   <= CNT_INIT;
                            if (req_wen) begin
                                mem_wen_r   <= 1'b1;
                                mem_waddr_r <= req_word_addr_s;
                                mem_wmask_r <= {4'b0000, req_mask_s};
                                mem_wdata_r <= req_wdata << {req_off_s, 3'b000};
                            end else begin
                                mem_ren_r   <= 1'b1;
                                mem_raddr_r <= req_word_addr_s;
                                mem_rmask_r <= {4'b0000, req_mask_s};
                            end
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (wen_r) begin
                        mem_wen_r    <= 1'b0;
                        mem_waddr_r  <= {MEM_ADDR_WIDTH{1'b0}};
                        mem_wmask_r  <= 8'h00;
                        mem_wdata_r  <= {DATA_WIDTH{1'b0}};
                        resp_valid_r <= 1'b1;
                        resp_rdata_r <= {DATA_WIDTH{1'b0}};
                        state_r      <= ST_RESP;
                    end else if (cnt_r == CNT_ZERO) begin
                        mem_ren_r    <= 1'b0;
                        mem_raddr_r  <= {MEM_ADDR_WIDTH{1'b0}};
                        mem_rmask_r  <= 8'h00;
                        resp_valid_r <= 1'b1;
                        resp_rdata_r <= load_align(size_r, uns_r, mem_rdata, off_r);
                        state_r      <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= {DATA_WIDTH{1'b0}};
                        req_ready_r  <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else begin
                        resp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= {DATA_WIDTH{1'b0}};
                    mem_ren_r    <= 1'b0;
                    mem_wen_r    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign mem_ren    = mem_ren_r;
    assign mem_raddr  = mem_raddr_r;
    assign mem_rmask  = mem_rmask_r;
    assign mem_wen    = mem_wen_r;
    assign mem_waddr  = mem_waddr_r;
    assign mem_wmask  = mem_wmask_r;
    assign mem_wdata  = mem_wdata_r;

endmodule

// File: doc/ysyx_23060201_lsu.md
Name: ysyx_23060201_lsu

Overview:
- Load/store unit: the initiator side of the core's data-memory port.
- Accepts one load or store request from the execute stage over a valid/ready handshake.
- Drives the word-aligned memory read/write port with byte-lane masks, captures read data, then aligns and sign/zero-extends it.
- Returns the result to write-back over a second valid/ready handshake. One transaction is in flight at a time.

Parameters:
- MEM_ADDR_WIDTH, 32, byte-address width of the request and memory ports.
- DATA_WIDTH, 32, data width; the block supports only 32.
- MEM_LAT, 1, load access cycles (at least 1); mem_ren is held this many cycles, and rdata is sampled at the last one.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  LSU can accept a request; equals 1 only in IDLE.
- req_wen  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  MEM_ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_WIDTH  aligned and extended load data; 0 for stores.
- resp_err  out  1  misaligned access (see Optional Feature).
- mem_ren  out  1  memory read enable.
- mem_raddr  out  MEM_ADDR_WIDTH  word-aligned read address ({addr[31:2],2'b00}).
- mem_rmask  out  8  byte-lane mask; bits [7:4] are always 0.
- mem_rdata  in  DATA_WIDTH  memory read data, combinationally valid while mem_ren=1.
- mem_wen  out  1  memory write enable; the write occurs on the posedge where it is 1.
- mem_waddr  out  MEM_ADDR_WIDTH  word-aligned write address.
- mem_wmask  out  8  byte-lane write mask.
- mem_wdata  out  DATA_WIDTH  lane-shifted store data.

Behaviour:
- Reset (async, rst=1): state=IDLE; latched request, counter and captured data are cleared.
  - Outputs during and after reset: resp_valid=0, resp_rdata=0, resp_err=0, all mem_* outputs=0, req_ready=1.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: on req_valid&&req_ready, latch wen/funct3/addr/wdata and go to ACCESS. An erroring request (feature on) goes straight to RESP with resp_err=1.
  - ACCESS (store): mem_wen=1 for exactly one cycle, then go to RESP.
  - ACCESS (load): mem_ren=1 for MEM_LAT consecutive cycles, counted by a down-counter. mem_rdata is captured at the posedge ending the final cycle, then go to RESP.
  - RESP: resp_valid=1; outputs are held stable until resp_ready=1, then return to IDLE. There is no IDLE bypass, so the next request is accepted one cycle after the response handshake.
- mem_* outputs are 0 in every state other than ACCESS. mem_ren and mem_wen are never both 1.
- Lane mask, with off=addr[1:0]:
  - B/BU: 4'b0001<<off.
  - H/HU: 4'b0011<<off.
  - W: 4'b1111.
  - The same mask drives mem_rmask for loads and mem_wmask for stores.
- Store data: mem_wdata = req_wdata << (8*off).
- Load data: sh = mem_rdata >> (8*off).
  - B: sign-extend sh[7:0].
  - BU: zero-extend sh[7:0].
  - H: sign-extend sh[15:0].
  - HU: zero-extend sh[15:0].
  - W: sh.
- Unsupported funct3 (011, 110, 111) is treated as W.
- Misaligned access: a halfword with addr[0]=1, or a word with addr[1:0]!=0.
- Latency: a store completes with resp_valid 2 cycles after acceptance; a load with resp_valid MEM_LAT+1 cycles after acceptance.
- Async reset asserted mid-ACCESS or mid-RESP aborts the transaction and returns to reset values. A write already committed on an earlier edge is not undone.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned request skips ACCESS and issues no mem_ren/mem_wen.
  - RESP is returned with resp_err=1 and resp_rdata=0.
- Undefined:
  - resp_err is tied to 0.
  - Misaligned addresses are forced aligned by clearing addr[0] for halfwords and addr[1:0] for words, and the access proceeds normally.

Test Plan:
- Reset asserted mid-load (MEM_LAT=3, second ACCESS cycle) -> mem_ren drops to 0 asynchronously, req_ready=1, resp_valid never asserts.
- SW addr=0x80000004 data=0xDEADBEEF -> one cycle with mem_wen=1, mem_waddr=0x80000004, mem_wmask=0x0F, mem_wdata=0xDEADBEEF; resp_valid 2 cycles after acceptance.
- SB addr=0x80000003 data=0x000000A5 -> mem_wmask=0x08, mem_wdata=0xA5000000.
- LB addr=0x80000002 with mem_rdata=0x12F45678 -> mem_rmask=0x04, resp_rdata=0xFFFFFFF4. LBU at the same address -> 0x000000F4.
- LH addr=0x80000002 with mem_rdata=0x8001ABCD, MEM_LAT=3 -> mem_ren high for 3 cycles, resp_rdata=0xFFFF8001. Hold resp_ready=0 for 4 cycles -> resp_valid and resp_rdata stable, req_ready=0.
- LW addr=0x80000001:
  - LSU_MISALIGN_TRAP_EN defined -> no mem_ren, resp_err=1, resp_rdata=0.
  - Undefined -> mem_raddr=0x80000000, mem_rmask=0x0F, resp_err=0.
